// File: rtl/papigpu_defs.sv
// Shared definitions for the SDRAM port arbiter: FSM encoding, requester IDs and
// default timing parameters.
package papigpu_defs;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StIssue   = 2'd1,
      StWaitRsp = 2'd2,
      StRefresh = 2'd3
   } arb_state_e;

   localparam logic REQ_LOADER = 1'b0;
   localparam logic REQ_VGA    = 1'b1;

   localparam int unsigned DEF_REFRESH_PERIOD = 780;
   localparam int unsigned DEF_STARVE_LIMIT   = 8;

   function automatic logic [1:0] req_onehot(input logic id);
      return (id == REQ_VGA) ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Periodic refresh scheduler: down-counter, pending flag cleared by the arbiter, and a
// sticky overrun flag for a period that expires before the previous refresh was serviced.
module sdram_refresh_timer
   import papigpu_defs::*;
#(
   parameter int unsigned REFRESH_PERIOD = DEF_REFRESH_PERIOD
) (
   input  logic iClock,
   input  logic iReset,
   input  logic iClear,
   output logic oDue,
   output logic oOverrun
);

   localparam int unsigned CntW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
   localparam logic [CntW-1:0] Reload = CntW'(REFRESH_PERIOD - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            pending_q, pending_d;
   logic            overrun_q, overrun_d;
   logic            expire;

   always_comb begin
      expire    = (cnt_q == '0);
      cnt_d     = expire ? Reload : cnt_q - CntW'(1);
      pending_d = pending_q;
      if (iClear) pending_d = 1'b0;
      // A fresh expiry wins over a clear landing in the same cycle.
      if (expire) pending_d = 1'b1;
      overrun_d = overrun_q | (expire & pending_q & ~iClear);
   end

   always_ff @(posedge iClock) begin
      if (iReset) begin
         cnt_q     <= Reload;
         pending_q <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         overrun_q <= overrun_d;
      end
   end

   // Expiry is visible the same cycle so it outranks a request arriving alongside it.
   assign oDue     = pending_q | expire;
   assign oOverrun = overrun_q;

endmodule

// File: rtl/sdram_port_arb.sv
// Two-requester arbiter for the SDRAM command port with refresh scheduling.
// Optional loader anti-starvation counter is compiled in with SDRAM_ARB_STARVE_EN.
module sdram_port_arb
   import papigpu_defs::*;
#(
   parameter int unsigned ADDR_W         = 22,
   parameter int unsigned DATA_W         = 16,
   parameter int unsigned REFRESH_PERIOD = DEF_REFRESH_PERIOD,
   parameter int unsigned STARVE_LIMIT   = DEF_STARVE_LIMIT
) (
   input  logic              iClock,
   input  logic              iReset,
   input  logic              iReq0,
   input  logic              iWe0,
   input  logic [ADDR_W-1:0] iAddr0,
   input  logic [DATA_W-1:0] iWData0,
   output logic              oGnt0,
   output logic              oDone0,
   input  logic              iReq1,
   input  logic              iWe1,
   input  logic [ADDR_W-1:0] iAddr1,
   input  logic [DATA_W-1:0] iWData1,
   output logic              oGnt1,
   output logic              oDone1,
   output logic [DATA_W-1:0] oRData,
   output logic              oCmdValid,
   input  logic              iCmdReady,
   output logic              oCmdWe,
   output logic [ADDR_W-1:0] oCmdAddr,
   output logic [DATA_W-1:0] oCmdWData,
   input  logic              iRspValid,
   input  logic [DATA_W-1:0] iRspData,
   output logic              oRefReq,
   input  logic              iRefAck,
   output logic              oRefOverrun
);

   arb_state_e        state_q, state_d;
   logic              owner_q, owner_d;
   logic              cmd_we_q, cmd_we_d;
   logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
   logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [1:0]        done_q, done_d;
   logic              take;
   logic              grant_any;
   logic              grant_id;
   logic              starved;
   logic              ref_due;
   logic              ref_clear;

   assign ref_clear = (state_q == StRefresh) & iRefAck;

   sdram_refresh_timer #(
      .REFRESH_PERIOD(REFRESH_PERIOD)
   ) u_refresh_timer (
      .iClock  (iClock),
      .iReset  (iReset),
      .iClear  (ref_clear),
      .oDue    (ref_due),
      .oOverrun(oRefOverrun)
   );

`ifdef SDRAM_ARB_STARVE_EN
   localparam int unsigned StW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
   localparam logic [StW-1:0] StarveMax = StW'(STARVE_LIMIT);

   logic [StW-1:0] starve_q, starve_d;

   assign starved = iReq0 & (starve_q >= StarveMax);

   // Counts VGA wins the loader sat through; saturates so the override stays armed.
   always_comb begin
      starve_d = starve_q;
      if (take) begin
         if (grant_id == REQ_LOADER) begin
            starve_d = '0;
         end else if (iReq0 && (starve_q != StarveMax)) begin
            starve_d = starve_q + StW'(1);
         end
      end
   end

   always_ff @(posedge iClock) begin
      if (iReset) starve_q <= '0;
      else        starve_q <= starve_d;
   end
`else
   logic unused_starve_limit;
   assign unused_starve_limit = ^STARVE_LIMIT;
   assign starved = 1'b0;
`endif

   assign grant_any = iReq0 | iReq1;
   assign grant_id  = (iReq1 && !starved) ? REQ_VGA : REQ_LOADER;

   always_ff @(posedge iClock) begin
      if (iReset) state_q <= StIdle;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      take    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (ref_due) begin
               state_d = StRefresh;
            end else if (grant_any) begin
               state_d = StIssue;
               take    = 1'b1;
            end
         end
         StIssue: begin
            if (iCmdReady) state_d = cmd_we_q ? StIdle : StWaitRsp;
         end
         StWaitRsp: begin
            if (iRspValid) state_d = StIdle;
         end
         StRefresh: begin
            // Arbitrate on the ack cycle so a waiting requester is granted right after.
            if (iRefAck) begin
               if (grant_any) begin
                  state_d = StIssue;
                  take    = 1'b1;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      owner_d     = owner_q;
      cmd_we_d    = cmd_we_q;
      cmd_addr_d  = cmd_addr_q;
      cmd_wdata_d = cmd_wdata_q;
      rdata_d     = rdata_q;
      done_d      = 2'b00;
      if (take) begin
         owner_d     = grant_id;
         cmd_we_d    = (grant_id == REQ_VGA) ? iWe1 : iWe0;
         cmd_addr_d  = (grant_id == REQ_VGA) ? iAddr1 : iAddr0;
         cmd_wdata_d = (grant_id == REQ_VGA) ? iWData1 : iWData0;
      end
      if ((state_q == StIssue) && iCmdReady && cmd_we_q) begin
         done_d = req_onehot(owner_q);
      end
      if ((state_q == StWaitRsp) && iRspValid) begin
         done_d  = req_onehot(owner_q);
         rdata_d = iRspData;
      end
   end

   always_ff @(posedge iClock) begin
      if (iReset) begin
         owner_q     <= REQ_LOADER;
         cmd_we_q    <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         rdata_q     <= '0;
         done_q      <= 2'b00;
      end else begin
         owner_q     <= owner_d;
         cmd_we_q    <= cmd_we_d;
         cmd_addr_q  <= cmd_addr_d;
         cmd_wdata_q <= cmd_wdata_d;
         rdata_q     <= rdata_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      oGnt0     = ((state_q == StIssue) || (state_q == StWaitRsp)) && (owner_q == REQ_LOADER);
      oGnt1     = ((state_q == StIssue) || (state_q == StWaitRsp)) && (owner_q == REQ_VGA);
      oCmdValid = (state_q == StIssue);
      oRefReq   = (state_q == StRefresh);
      oCmdWe    = cmd_we_q;
      oCmdAddr  = cmd_addr_q;
      oCmdWData = cmd_wdata_q;
      oRData    = rdata_q;
      oDone0    = done_q[0];
      oDone1    = done_q[1];
   end

endmodule
